// File: rtl/pipe_pkg.sv
// Shared pipeline constants: data width, register address width and MEM/WB control bundle layout.
package pipe_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned REG_ADDR_W    = 5;
  localparam int unsigned CTRL_W        = 9;
  localparam int unsigned CTRL_REGWRITE = 5;
  localparam int unsigned CTRL_MEMTOREG = 6;
  localparam int unsigned WB_CNT_W      = 32;

  // Writeback source select: load data when MemtoReg is set, otherwise the ALU result.
  function automatic logic [XLEN-1:0] wb_select(input logic          memtoreg,
                                                input logic [XLEN-1:0] load_data,
                                                input logic [XLEN-1:0] alu_data);
    return memtoreg ? load_data : alu_data;
  endfunction

endpackage

// File: rtl/regfile_core.sv
// Register storage array: two combinational read ports, one write port, x0 hardwired to zero.
module regfile_core
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN  = pipe_pkg::XLEN,
  parameter int unsigned NREGS = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [XLEN-1:0]       wdata,
  input  logic [REG_ADDR_W-1:0] raddr1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic [XLEN-1:0]       rdata1_c,
  output logic [XLEN-1:0]       rdata2_c
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  // Next array contents: a single write per edge, never to x0.
  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) begin
      regs_d[waddr] = wdata;
    end
  end

  // Array state; reset clears every entry without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports; address 0 always returns zero.
  always_comb begin
    rdata1_c = (raddr1 == '0) ? '0 : regs_q[raddr1];
    rdata2_c = (raddr2 == '0) ? '0 : regs_q[raddr2];
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage + register file: writeback mux, commit counter and optional
// same-cycle write-through bypass (enabled by defining WB_BYPASS_EN).
module wb_regfile
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN  = pipe_pkg::XLEN,
  parameter int unsigned NREGS = 32
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [XLEN-1:0]       Read_data_in,
  input  logic [XLEN-1:0]       ALU_result_in,
  input  logic [CTRL_W-1:0]     ctrl_sig_in,
  input  logic                  write_en,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data,
  output logic [XLEN-1:0]       wb_data,
  output logic [WB_CNT_W-1:0]   wb_count
);

  logic                commit_c;
  logic [XLEN-1:0]     core_rdata1_c;
  logic [XLEN-1:0]     core_rdata2_c;
  logic [WB_CNT_W-1:0] wb_count_q;
  logic [WB_CNT_W-1:0] wb_count_d;
  logic                unused_ctrl;

  // Only MemtoReg is consumed here; RegWrite arrives separately as write_en.
  assign unused_ctrl = ^{ctrl_sig_in[CTRL_W-1:CTRL_MEMTOREG+1], ctrl_sig_in[CTRL_MEMTOREG-1:0]};

  // Writeback source select and commit qualification (writes to x0 are dropped).
  always_comb begin
    wb_data  = wb_select(ctrl_sig_in[CTRL_MEMTOREG], Read_data_in, ALU_result_in);
    commit_c = write_en && (rd != '0);
  end

  regfile_core #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_core (
    .clk      (CLK),
    .rst_n    (RST_N),
    .we       (commit_c),
    .waddr    (rd),
    .wdata    (wb_data),
    .raddr1   (rs1),
    .raddr2   (rs2),
    .rdata1_c (core_rdata1_c),
    .rdata2_c (core_rdata2_c)
  );

  // Read data; with bypass a matching in-flight write is forwarded, but never during reset.
  always_comb begin
    rs1_data = core_rdata1_c;
    rs2_data = core_rdata2_c;
`ifdef WB_BYPASS_EN
    if (commit_c && RST_N && (rs1 == rd)) begin
      rs1_data = wb_data;
    end
    if (commit_c && RST_N && (rs2 == rd)) begin
      rs2_data = wb_data;
    end
`endif
  end

  // Commit counter next value; wraps naturally at 2^32.
  always_comb begin
    wb_count_d = wb_count_q + WB_CNT_W'(commit_c);
  end

  // Commit counter state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wb_count_q <= '0;
    end else begin
      wb_count_q <= wb_count_d;
    end
  end

  assign wb_count = wb_count_q;

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter XLEN, default 32, data width of the register file and all data ports, in bits.
REQ-002 Parameter NREGS, default 32, number of architectural registers; the address width is log2(NREGS) = 5.
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 RST_N  input  1  reset, asynchronous and active-low.
REQ-005 Read_data_in  input  XLEN  load data from the MEM/WB register.
REQ-006 ALU_result_in  input  XLEN  ALU result from the MEM/WB register.
REQ-007 ctrl_sig_in  input  9  control bundle from MEM/WB; bit 6 = MemtoReg, others ignored.
REQ-008 write_en  input  1  RegWrite from MEM/WB, equal to ctrl_sig_in[5].
REQ-009 rd  input  5  writeback destination register.
REQ-010 rs1, rs2  input  5 each  decode-stage read addresses.
REQ-011 rs1_data, rs2_data  output  XLEN each  read data, combinational from the array and bypass logic.
REQ-012 wb_data  output  XLEN  selected writeback value, combinational.
REQ-013 wb_count  output  32  registered count of committed writes.

Function
REQ-014 wb_data SHALL equal Read_data_in when ctrl_sig_in[6]=1, else ALU_result_in.
REQ-015 A commit SHALL occur at a rising CLK edge when write_en=1 and rd!=0; the edge writes wb_data into reg[rd].
REQ-016 Writes with rd=0 SHALL be dropped; reg[0] SHALL always read 0.
REQ-017 rsN_data SHALL be 0 when rsN=0, else reg[rsN], subject to REQ-026.
REQ-018 Both read ports SHALL be independent; rs1=rs2 SHALL return identical data.
REQ-019 wb_count SHALL increment by 1 on each commit, wrap from 0xFFFFFFFF to 0, and hold otherwise.
REQ-020 write_en=1 with an X-free rd and rd=0 SHALL NOT increment wb_count.
REQ-021 Write latency: data written at edge N SHALL be visible from the array after edge N.

Reset
REQ-022 While RST_N=0, all registers reg[0..NREGS-1] SHALL be 0 and wb_count SHALL be 0, regardless of CLK.
REQ-023 Deassertion of RST_N SHALL take effect at the next rising CLK edge; a write asserted on that edge SHALL commit.
REQ-024 Reset asserted mid-operation SHALL discard a write pending on the same edge.
REQ-025 During reset, outputs: rs1_data=rs2_data=0; wb_data SHALL still follow REQ-014.

Configuration
REQ-026 Macro WB_BYPASS_EN: when defined, if write_en=1, rd!=0 and rsN=rd, rsN_data SHALL equal wb_data in the same cycle (write-through); when undefined, rsN_data SHALL return the old array value until the edge.

Structure
REQ-027 Shared package pipe_pkg SHALL hold XLEN, REG_ADDR_W=5, CTRL_W=9, and the constants CTRL_REGWRITE=5 and CTRL_MEMTOREG=6.
REQ-028 The storage array with its two read ports and one write port SHALL be the sub-module regfile_core; the writeback mux, bypass and counter SHALL be in wb_regfile.

Verification
REQ-029 Reset: RST_N=0 mid-run -> all rs reads 0 and wb_count=0 immediately, without a clock edge.
REQ-030 ALU write: ALU_result_in=0x0000_00A5, ctrl[6]=0, write_en=1, rd=3, one edge, then rs1=3 -> rs1_data=0xA5 and wb_count=1.
REQ-031 Load write: Read_data_in=0xDEAD_BEEF, ALU_result_in=0x1, ctrl[6]=1, rd=7 -> reg7=0xDEADBEEF after the edge.
REQ-032 x0 guard: write 0xFFFF_FFFF to rd=0 -> rs1=0 reads 0 and wb_count is unchanged.
REQ-033 Same-cycle hazard: reg5=0x11, write 0x22 to rd=5 with rs2=5 -> rs2_data=0x22 before the edge with WB_BYPASS_EN, 0x11 without it; 0x22 after the edge in both builds.
REQ-034 Counter wrap: preload wb_count near 0xFFFF_FFFF by forced commits, two more commits -> wb_count=0x0000_0000 then 0x0000_0001.
